// File: rtl/bitserial_mac_array.sv
// rtl/bitserial_mac_array.sv - bit-serial MAC stage: MSB-first activation bits against BANKS weight banks
//
// Purpose: latches one activation vector and one weight tile per transaction,
// then processes one activation bit per cycle. Each bank shift-accumulates
// its per-bit partial sum into one full-precision result.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   transaction offered
//   in_ready   transaction can be accepted (from state and out_ready only)
//   act        activation vector, row r at [r*ABITS +: ABITS], unsigned
//   wgt        weights, bank b row r at [(b*ROWS+r)*WBITS +: WBITS]
//   prec       active activation bits; 0 or >ABITS selects ABITS
//   out_valid  result available, held until out_ready
//   out_ready  downstream accepts result
//   psum       bank b result at [b*ACCW +: ACCW]; zero unless out_valid
module bitserial_mac_array #(
    parameter int ROWS     = 16,
    parameter int BANKS    = 4,
    parameter int WBITS    = 4,
    parameter int ABITS    = 8,
    parameter bit SIGNED_W = 1'b1,
    localparam int ACCW    = WBITS + ABITS + $clog2(ROWS),
    localparam int PRW     = $clog2(ABITS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS*ABITS-1:0]        act,
    input  logic [BANKS*ROWS*WBITS-1:0]  wgt,
    input  logic [PRW-1:0]               prec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BANKS*ACCW-1:0]        psum
);

    localparam int KW = (ABITS > 1) ? $clog2(ABITS) : 1;
    // Partial sum of one bit plane: worst case ROWS * |min weight|.
    localparam int PW = WBITS + $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [ROWS*ABITS-1:0]         act_q;
    logic [BANKS*ROWS*WBITS-1:0]   wgt_q;
    logic [KW-1:0]                 bit_idx;
    logic [ACCW-1:0]               acc      [BANKS];
    logic [ACCW-1:0]               partial  [BANKS];
    logic [PW-1:0]                 bank_sum [BANKS];
    logic [ABITS-1:0]              row_bits;
    logic [PRW-1:0]                p_eff;
    logic                          accept;

    function automatic logic [PW-1:0] ext_w(input logic [WBITS-1:0] w);
        if (SIGNED_W) begin
            return {{(PW-WBITS){w[WBITS-1]}}, w};
        end
        return {{(PW-WBITS){1'b0}}, w};
    endfunction

    always_comb begin
        p_eff = prec;
        if (prec == '0 || prec > PRW'(ABITS)) begin
            p_eff = PRW'(ABITS);
        end
    end

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // One bit plane per cycle: sum the weights of rows whose current
    // activation bit is set, then widen to the accumulator width.
    always_comb begin
        row_bits = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_sum[b] = '0;
            for (int r = 0; r < ROWS; r++) begin
                row_bits = act_q[r*ABITS +: ABITS];
                if (row_bits[bit_idx]) begin
                    bank_sum[b] = bank_sum[b] + ext_w(wgt_q[(b*ROWS+r)*WBITS +: WBITS]);
                end
            end
            if (SIGNED_W) begin
                partial[b] = {{(ACCW-PW){bank_sum[b][PW-1]}}, bank_sum[b]};
            end else begin
                partial[b] = {{(ACCW-PW){1'b0}}, bank_sum[b]};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (bit_idx == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            act_q   <= '0;
            wgt_q   <= '0;
            bit_idx <= '0;
            for (int b = 0; b < BANKS; b++) acc[b] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                act_q   <= act;
                wgt_q   <= wgt;
                bit_idx <= KW'(p_eff - 1'b1);
                for (int b = 0; b < BANKS; b++) acc[b] <= '0;
            end else if (state == RUN) begin
                bit_idx <= bit_idx - 1'b1;
                for (int b = 0; b < BANKS; b++) acc[b] <= (acc[b] << 1) + partial[b];
            end
        end
    end

    // Accumulators are only exposed in DONE so a partial result never leaks.
    always_comb begin
        psum = '0;
        for (int b = 0; b < BANKS; b++) begin
            psum[b*ACCW +: ACCW] = (state == DONE) ? acc[b] : '0;
        end
    end

endmodule

// File: tb/tb_bitserial_mac_array.sv
// tb/tb_bitserial_mac_array.sv - self-checking bench for bitserial_mac_array
module tb_bitserial_mac_array;

    localparam int ROWS  = 16;
    localparam int BANKS = 4;
    localparam int WBITS = 4;
    localparam int ABITS = 8;
    localparam int ACCW  = 16;
    localparam int PRW   = 4;
    localparam int AW    = ROWS*ABITS;
    localparam int WW    = BANKS*ROWS*WBITS;
    localparam int SW    = BANKS*ACCW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] act = '0;
    logic [WW-1:0] wgt = '0;
    logic [PRW-1:0] prec = '0;

    logic          in_ready_s, out_valid_s, in_ready_u, out_valid_u;
    logic [SW-1:0] psum_s, psum_u;

    bitserial_mac_array #(.ROWS(ROWS), .BANKS(BANKS), .WBITS(WBITS), .ABITS(ABITS), .SIGNED_W(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .act(act), .wgt(wgt),
        .prec(prec), .out_valid(out_valid_s), .out_ready(out_ready), .psum(psum_s));

    bitserial_mac_array #(.ROWS(ROWS), .BANKS(BANKS), .WBITS(WBITS), .ABITS(ABITS), .SIGNED_W(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .act(act), .wgt(wgt),
        .prec(prec), .out_valid(out_valid_u), .out_ready(out_ready), .psum(psum_u));

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] es;
        logic [SW-1:0] eu;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            n_assert = 0;
    int            n_fail = 0;
    int            n_push = 0;
    int            lat;
    int            guard;
    logic [SW-1:0] held;

    function automatic logic [SW-1:0] model(input logic [AW-1:0] a, input logic [WW-1:0] w,
                                            input logic [PRW-1:0] p, input bit sgn);
        int pe, sum, av, wv;
        logic [SW-1:0] res;
        pe  = (p == 0 || int'(p) > ABITS) ? ABITS : int'(p);
        res = '0;
        for (int b = 0; b < BANKS; b++) begin
            sum = 0;
            for (int r = 0; r < ROWS; r++) begin
                av = int'(a[r*ABITS +: ABITS]) & ((1 << pe) - 1);
                wv = int'(w[(b*ROWS+r)*WBITS +: WBITS]);
                if (sgn && wv >= 8) wv = wv - 16;
                sum = sum + av * wv;
            end
            res[b*ACCW +: ACCW] = sum[ACCW-1:0];
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Evaluate both handshakes just before the edge, then advance one cycle.
    task automatic tick();
        #2;
        if (in_valid && in_ready_s) begin
            sb.push_back('{model(act, wgt, prec, 1'b1), model(act, wgt, prec, 1'b0)});
            n_push++;
        end
        if (out_valid_s && out_ready) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_psum_signed", psum_s, e.es);
                chk("sb_psum_unsigned", psum_u, e.eu);
                chk("sb_valid_unsigned", 64'(out_valid_u), 64'd1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [WW-1:0] w, input logic [PRW-1:0] p);
        act = a; wgt = w; prec = p; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        lat = 0;
        while (!out_valid_s && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [AW-1:0] a3;
    logic [WW-1:0] w3;

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid_s), 64'd0);
        chk("rst_psum", psum_s, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready_s), 64'd1);

        // All act=1, wgt=1, P=8
        start({ROWS{8'h01}}, {(BANKS*ROWS){4'h1}}, 4'd8);
        wait_out("t1", 8);
        chk("t1_psum_s", psum_s, {4{16'd16}});
        chk("t1_psum_u", psum_u, {4{16'd16}});
        release_out();

        // Signed minimum, prec=0 selects 8 bits
        start({ROWS{8'hFF}}, {(BANKS*ROWS){4'h8}}, 4'd0);
        wait_out("t2", 8);
        chk("t2_psum_s", psum_s, {4{16'h8080}});
        chk("t2_psum_u", psum_u, {4{16'h7F80}});
        release_out();

        // Unsigned maximum
        start({ROWS{8'hFF}}, {(BANKS*ROWS){4'hF}}, 4'd8);
        wait_out("t2b", 8);
        chk("t2b_psum_u", psum_u, {4{16'hEF10}});
        chk("t2b_psum_s", psum_s, {4{16'hF010}});
        release_out();

        // Precision mode: only bits 3..0 of 8'hF3 count
        a3 = '0; a3[7:0] = 8'hF3;
        w3 = '0; w3[3:0] = 4'd2; w3[ROWS*WBITS +: WBITS] = 4'hF;
        start(a3, w3, 4'd4);
        wait_out("t3", 4);
        chk("t3_psum_s", psum_s, {16'd0, 16'd0, 16'hFFFD, 16'd6});
        chk("t3_psum_u", psum_u, {16'd0, 16'd0, 16'd45, 16'd6});
        release_out();

        // P=1: bit 7 ignored, single RUN cycle
        start({ROWS{8'h81}}, {(BANKS*ROWS){4'h3}}, 4'd1);
        wait_out("t4", 1);
        chk("t4_psum_s", psum_s, {4{16'h0030}});
        release_out();

        // Backpressure then back-to-back DONE->RUN
        start({ROWS{8'h05}}, {(BANKS*ROWS){4'h2}}, 4'd3);
        wait_out("t5", 3);
        held = psum_s;
        chk("t5_psum_s", held, {4{16'h00A0}});
        for (int i = 0; i < 5; i++) begin
            act = $urandom; wgt = {$urandom, $urandom};
            tick();
            chk("t5_hold_psum", psum_s, held);
            chk("t5_hold_in_ready", 64'(in_ready_s), 64'd0);
            chk("t5_hold_valid", 64'(out_valid_s), 64'd1);
        end
        act = {ROWS{8'h0A}}; wgt = {(BANKS*ROWS){4'hE}}; prec = 4'd4;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t5_b2b_in_ready", 64'(in_ready_s), 64'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_b2b_running", 64'({out_valid_s, in_ready_s}), 64'd0);
        wait_out("t5b", 4);
        chk("t5b_psum_s", psum_s, {4{16'hFEC0}});
        chk("t5b_psum_u", psum_u, {4{16'h08C0}});
        release_out();

        // Reset during RUN cycle 3
        start({ROWS{8'hFF}}, {(BANKS*ROWS){4'h7}}, 4'd8);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid_s), 64'd0);
        chk("t6_rst_psum", psum_s, 64'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_in_ready", 64'(in_ready_s), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_no_stale", 64'(out_valid_s), 64'd0);
        end
        start({ROWS{8'h03}}, {(BANKS*ROWS){4'h7}}, 4'd8);
        wait_out("t6b", 8);
        chk("t6b_psum_s", psum_s, {4{16'd336}});
        release_out();

        // Randomised traffic with stalls; inputs churn every cycle
        n_push = 0;
        guard = 0;
        while (n_push < 200 && guard < 20000) begin
            act = {$urandom, $urandom, $urandom, $urandom};
            wgt = {$urandom, $urandom};
            prec = PRW'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
        end
        chk("rand_accepted", 64'(n_push), 64'd200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((sb.size() > 0 || out_valid_s) && guard < 200) begin
            tick();
            guard++;
        end
        chk("rand_drained", 64'(sb.size()), 64'd0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
